axil_rr_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer that shares the single AXI4-Lite port of the peripheral subsystem (the APB bridge wrapper).
- Typical requesters: CPU data port (0) and a DMA/boot-config engine (1).
- Each requester uses a simple valid/ready request interface and gets a one-cycle response pulse.
- Only one AXI-Lite transaction is in flight at a time.

---
 rtl/axil_rr_arbiter_pkg.sv | 13 +
 rtl/axil_rr_arbiter_if.sv | 27 ++
 rtl/axil_rr_arbiter_rr_pick2.sv | 8 +
 rtl/axil_rr_arbiter.sv | 85 ++++++++
 tb/tb_axil_rr_arbiter.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/axil_rr_arbiter_pkg.sv
// axil_rr_arbiter_pkg: FSM state encoding and AXI-Lite width constants shared by the arbiter slice
package axil_rr_arbiter_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4
  } state_t;
endpackage

// File: rtl/axil_rr_arbiter_if.sv
// axil_rr_arbiter_if: AXI-Lite bus (aw/w/b/ar/r channels, no resp fields); master drives valids/addr/data, slave drives readies/b/r
interface axil_rr_arbiter_if;
  import axil_rr_arbiter_pkg::*;
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              bvalid;
  logic              bready;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, arready, rvalid, rdata
  );
  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, arready, rvalid, rdata
  );
endinterface

// File: rtl/axil_rr_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin pick; valid[1:0] + last winner in, one-hot grant out (tie goes to ~last)
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);
  always_comb grant = &valid ? (last ? 2'b01 : 2'b10) : valid;
endmodule

// File: rtl/axil_rr_arbiter.sv
// axil_rr_arbiter: two-requester round-robin sequencer onto one AXI-Lite master; clk_i/rst_n_i, req_* valid/ready requests, rsp_* completion pulse, m_axi bus
module axil_rr_arbiter
  import axil_rr_arbiter_pkg::*;
#(
  parameter logic RR_INIT = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [1:0]  req_valid_i,
  output logic [1:0]  req_ready_o,
  input  logic [1:0]  req_we_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  input  logic [7:0]  req_wstrb_i,
  output logic [1:0]  rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  axil_rr_arbiter_if.master m_axi
);
  state_t            state, state_n;
  logic              last_q, g_q, aw_done, w_done;
  logic [1:0]        grant;
  logic              g, aw_hs, w_hs, done;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  rr_pick2 u_pick (
    .valid(req_valid_i),
    .last (last_q),
    .grant(grant)
  );
  assign g              = grant[1];
  assign m_axi.awvalid  = state == WADDR && !aw_done;
  assign m_axi.wvalid   = state == WADDR && !w_done;
  assign m_axi.bready   = state == WRESP;
  assign m_axi.arvalid  = state == RADDR;
  assign m_axi.rready   = state == RDATA;
  assign m_axi.awaddr   = addr_q;
  assign m_axi.araddr   = addr_q;
  assign m_axi.wdata    = wdata_q;
  assign m_axi.wstrb    = wstrb_q;
  assign aw_hs          = m_axi.awvalid && m_axi.awready;
  assign w_hs           = m_axi.wvalid && m_axi.wready;
  assign done           = (state == WRESP && m_axi.bvalid) || (state == RDATA && m_axi.rvalid);
  // gated by reset so the accept pulse stays low while rst_n_i is held
  assign req_ready_o    = (state == IDLE && rst_n_i) ? grant : 2'b00;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = |req_valid_i ? (req_we_i[g] ? WADDR : RADDR) : IDLE;
      WADDR:   state_n = ((aw_done || aw_hs) && (w_done || w_hs)) ? WRESP : WADDR;
      WRESP:   state_n = m_axi.bvalid ? IDLE : WRESP;
      RADDR:   state_n = m_axi.arready ? RDATA : RADDR;
      RDATA:   state_n = m_axi.rvalid ? IDLE : RDATA;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      last_q      <= ~RR_INIT;
      g_q         <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_o <= 2'b00;
      rsp_rdata_o <= '0;
    end else begin
      state       <= state_n;
      // done flags clear automatically once the FSM leaves WADDR
      aw_done     <= state_n == WADDR && (aw_done || aw_hs);
      w_done      <= state_n == WADDR && (w_done || w_hs);
      rsp_valid_o <= done ? (g_q ? 2'b10 : 2'b01) : 2'b00;
      if (state == RDATA && m_axi.rvalid) rsp_rdata_o <= m_axi.rdata;
      if (state == IDLE && |req_valid_i) begin
        last_q  <= g;
        g_q     <= g;
        addr_q  <= g ? req_addr_i[63:32] : req_addr_i[31:0];
        wdata_q <= g ? req_wdata_i[63:32] : req_wdata_i[31:0];
        wstrb_q <= g ? req_wstrb_i[7:4] : req_wstrb_i[3:0];
      end
    end
  end
endmodule

// File: tb/tb_axil_rr_arbiter.sv
// tb_axil_rr_arbiter: directed self-checking bench for axil_rr_arbiter with a hand-driven AXI-Lite slave
module tb_axil_rr_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic [31:0] rsp_rdata;
  int          tests = 0;
  int          fails = 0;
  axil_rr_arbiter_if m_axi ();
  axil_rr_arbiter #(.RR_INIT(1'b0)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_we_i   (req_we),
    .req_addr_i (req_addr),
    .req_wdata_i(req_wdata),
    .req_wstrb_i(req_wstrb),
    .rsp_valid_o(rsp_valid),
    .rsp_rdata_o(rsp_rdata),
    .m_axi      (m_axi)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // called one cycle after accept (FSM in RADDR); slave gives arready at once, rvalid two cycles later
  task automatic serve_read(input logic [31:0] data, input logic gr);
    m_axi.arready = 1'b1;
    #1 chk("busy_ready_ar", {62'd0, req_ready}, 64'd0);
    chk("busy_arvalid", {63'd0, m_axi.arvalid}, 64'd1);
    tick();
    m_axi.arready = 1'b0;
    #1 chk("busy_ready_r1", {62'd0, req_ready}, 64'd0);
    tick();
    m_axi.rvalid = 1'b1;
    m_axi.rdata  = data;
    #1 chk("busy_ready_r2", {62'd0, req_ready}, 64'd0);
    tick();
    m_axi.rvalid = 1'b0;
    m_axi.rdata  = 32'h0;
    #1 chk("srv_rsp", {62'd0, rsp_valid}, gr ? 64'd2 : 64'd1);
    chk("srv_rdata", {32'd0, rsp_rdata}, {32'd0, data});
  endtask
  initial begin
    rst_n = 1'b0;
    req_valid = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    m_axi.awready = 1'b0; m_axi.wready = 1'b0; m_axi.bvalid = 1'b0;
    m_axi.arready = 1'b0; m_axi.rvalid = 1'b0; m_axi.rdata = 32'h0;
    tick();
    tick();
    req_valid = 2'b11;
    #1 chk("rst_ready", {62'd0, req_ready}, 64'd0);
    chk("rst_ctl", {59'd0, m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready}, 64'd0);
    chk("rst_rsp", {30'd0, rsp_valid, rsp_rdata}, 64'd0);
    chk("rst_addr", {m_axi.awaddr, m_axi.araddr}, 64'd0);
    chk("rst_wdata", {28'd0, m_axi.wstrb, m_axi.wdata}, 64'd0);
    req_valid = 2'b00;
    rst_n = 1'b1;
    tick();
    req_we = 2'b00; req_addr = {32'h0, 32'h0300_1004}; req_valid = 2'b01;
    #1 chk("rd_ready", {62'd0, req_ready}, 64'd1);
    tick();
    req_valid = 2'b00; m_axi.arready = 1'b1;
    #1 chk("rd_ar", {31'd0, m_axi.arvalid, m_axi.araddr}, {31'd0, 1'b1, 32'h0300_1004});
    chk("rd_ready_drop", {62'd0, req_ready}, 64'd0);
    tick();
    m_axi.arready = 1'b0;
    #1 chk("rd_rready", {62'd0, m_axi.arvalid, m_axi.rready}, 64'd1);
    tick();
    m_axi.rvalid = 1'b1; m_axi.rdata = 32'hDEAD_BEEF;
    #1 chk("rd_norsp", {62'd0, rsp_valid}, 64'd0);
    tick();
    m_axi.rvalid = 1'b0; m_axi.rdata = 32'h0;
    #1 chk("rd_rsp", {62'd0, rsp_valid}, 64'd1);
    chk("rd_rdata", {32'd0, rsp_rdata}, 64'hDEAD_BEEF);
    tick();
    #1 chk("rd_pulse", {62'd0, rsp_valid}, 64'd0);
    chk("rd_hold", {32'd0, rsp_rdata}, 64'hDEAD_BEEF);
    req_we = 2'b10; req_addr = {32'h0300_2000, 32'h0}; req_wdata = {32'h0000_00A5, 32'h0};
    req_wstrb = 8'h10; req_valid = 2'b10;
    #1 chk("wr_ready", {62'd0, req_ready}, 64'd2);
    tick();
    req_valid = 2'b00; m_axi.wready = 1'b1;
    #1 chk("wr_valids", {62'd0, m_axi.awvalid, m_axi.wvalid}, 64'd3);
    chk("wr_awaddr", {32'd0, m_axi.awaddr}, 64'h0300_2000);
    chk("wr_wdata", {28'd0, m_axi.wstrb, m_axi.wdata}, {28'd0, 4'h1, 32'h0000_00A5});
    tick();
    m_axi.wready = 1'b0; m_axi.awready = 1'b1;
    #1 chk("wr_wdrop", {62'd0, m_axi.awvalid, m_axi.wvalid}, 64'd2);
    tick();
    m_axi.awready = 1'b0; m_axi.bvalid = 1'b1;
    #1 chk("wr_bready", {61'd0, m_axi.awvalid, m_axi.wvalid, m_axi.bready}, 64'd1);
    tick();
    m_axi.bvalid = 1'b0;
    #1 chk("wr_rsp", {62'd0, rsp_valid}, 64'd2);
    chk("wr_bdrop", {63'd0, m_axi.bready}, 64'd0);
    req_we = 2'b00; req_addr = {32'h0, 32'h0000_1000}; req_valid = 2'b01;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("tp_accept", {62'd0, req_ready}, 64'd1);
      tick();
      serve_read(32'h100 + i, 1'b0);
    end
    req_valid = 2'b00;
    tick();
    req_we = 2'b01; req_addr = {32'h0000_2222, 32'h0300_3000};
    req_wdata = {32'h0, 32'h1234_5678}; req_wstrb = 8'h0F; req_valid = 2'b01;
    #1 chk("bp_accept", {62'd0, req_ready}, 64'd1);
    tick();
    req_valid = 2'b11;
    for (int i = 0; i < 10; i++) begin
      #1 chk("bp_hold", {30'd0, m_axi.awvalid, m_axi.wvalid, m_axi.awaddr}, {30'd0, 2'b11, 32'h0300_3000});
      chk("bp_wdata", {32'd0, m_axi.wdata}, 64'h1234_5678);
      chk("bp_noaccept", {62'd0, req_ready}, 64'd0);
      tick();
    end
    m_axi.awready = 1'b1; m_axi.wready = 1'b1;
    tick();
    m_axi.awready = 1'b0; m_axi.wready = 1'b0; m_axi.bvalid = 1'b1;
    #1 chk("bp_bready", {62'd0, m_axi.bready, req_ready[0] | req_ready[1]}, 64'd2);
    tick();
    m_axi.bvalid = 1'b0; req_valid = 2'b00;
    #1 chk("bp_rsp", {62'd0, rsp_valid}, 64'd1);
    tick();
    req_we = 2'b00; req_addr = {32'h0000_0001, 32'h0300_1008}; req_valid = 2'b01;
    #1 chk("mr_accept", {62'd0, req_ready}, 64'd1);
    tick();
    req_valid = 2'b11; m_axi.arready = 1'b1;
    #1;
    tick();
    m_axi.arready = 1'b0;
    #1 chk("mr_rdata_state", {63'd0, m_axi.rready}, 64'd1);
    rst_n = 1'b0;
    #1 chk("mr_ctl", {59'd0, m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready}, 64'd0);
    chk("mr_ready", {62'd0, req_ready}, 64'd0);
    chk("mr_araddr", {32'd0, m_axi.araddr}, 64'd0);
    m_axi.rvalid = 1'b1; m_axi.rdata = 32'h5555_AAAA;
    tick();
    #1 chk("mr_norsp", {30'd0, rsp_valid, rsp_rdata}, 64'd0);
    m_axi.rvalid = 1'b0; m_axi.rdata = 32'h0;
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rr_grant", {62'd0, req_ready}, (i % 2 == 1) ? 64'd2 : 64'd1);
      tick();
      serve_read(32'hC0DE_0000 + i, i % 2 == 1);
    end
    req_valid = 2'b00;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
